boa_mem_arbiter: RTL

//   Shares one memory port between two CPU-side requesters: port A (IF program bus) and port B (MEM data bus).

---
 rtl/boa_mem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/boa_mem_arbiter.sv
// Two-port memory arbiter: shares one memory port between the IF program bus (A)
// and the MEM data bus (B), holding a grant until the memory reports completion.
module boa_mem_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1,
   parameter bit FIRST_PORT  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   // Port A (program bus)
   input  logic        a_re,
   input  logic [3:0]  a_we,
   input  logic [29:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic [31:0] a_rdata,
   output logic        a_ready,
   // Port B (data bus)
   input  logic        b_re,
   input  logic [3:0]  b_we,
   input  logic [29:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic [31:0] b_rdata,
   output logic        b_ready,
   // Memory side
   output logic        m_re,
   output logic [3:0]  m_we,
   output logic [29:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ready,
   // Status
   output logic        busy,
   output logic        owner
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t state_reg;
   logic   owner_reg;
   logic   last_reg;
   logic   busy_reg;

   // Per-port views, index 0 = A, index 1 = B
   logic [1:0]        port_re;
   logic [1:0][3:0]   port_we;
   logic [1:0][29:0]  port_addr;
   logic [1:0][31:0]  port_wdata;
   logic [1:0]        port_req;
   logic [1:0]        port_ready;

   logic sel;
   logic req_sel;
   logic active;

   assign port_re    = {b_re, a_re};
   assign port_we    = {b_we, a_we};
   assign port_addr  = {b_addr, a_addr};
   assign port_wdata = {b_wdata, a_wdata};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         localparam logic PID = 1'(gi);
         assign port_req[gi]   = port_re[gi] | (|port_we[gi]);
         assign port_ready[gi] = m_ready & active & (sel == PID);
      end
   endgenerate

   // In BUSY the lock owner is the only candidate; arbitration happens only in IDLE.
   always_comb begin
      sel = owner_reg;
      if (state_reg == IDLE) begin
         case (port_req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ROUND_ROBIN ? ~last_reg : 1'b0;
            default: sel = 1'b0;
         endcase
      end
   end

   assign req_sel = port_req[sel];
   // Memory outputs stay quiet while reset is held, independent of the clock.
   assign active  = req_sel & rst;

   always_comb begin
      m_re    = 1'b0;
      m_we    = 4'h0;
      m_addr  = 30'h0;
      m_wdata = 32'h0;
      if (active) begin
         m_re    = port_re[sel];
         m_we    = port_we[sel];
         m_addr  = port_addr[sel];
         m_wdata = port_wdata[sel];
      end
   end

   assign a_ready = port_ready[0];
   assign b_ready = port_ready[1];
   assign a_rdata = m_rdata;
   assign b_rdata = m_rdata;
   assign busy    = busy_reg;
   assign owner   = owner_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         owner_reg <= 1'b0;
         last_reg  <= ~FIRST_PORT;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_sel) begin
                  if (m_ready) begin
                     last_reg <= sel;
                  end else begin
                     state_reg <= BUSY;
                     owner_reg <= sel;
                     busy_reg  <= 1'b1;
                  end
               end
            end
            BUSY: begin
               // Completion and abort (owner withdrew) both release the lock.
               if (!req_sel || m_ready) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  last_reg  <= owner_reg;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule
